snow64_bfloat16_vector_cast_from_int: RTL

- Sequencer directly upstream and downstream of the scalar BFloat16 int-to-float cast unit.
- Accepts one 256-bit vector line of packed 8/16/32/64-bit integers.
- Issues one scalar cast command per element to the cast unit and collects each 16-bit BFloat16 result.
- Delivers the whole converted line as one packed output. The cast unit is not instantiated inside; its ports are exposed so the vector ALU wrapper pairs the two.

---
 rtl/snow64_bfloat16_vector_cast_from_int_pkg.sv | 51 +++++
 rtl/snow64_vector_elem_extract.sv | 40 ++++
 rtl/snow64_bfloat16_vector_cast_from_int.sv | 120 ++++++++++++
 3 files changed

// File: rtl/snow64_bfloat16_vector_cast_from_int_pkg.sv
// Shared types for the BFloat16 vector int-to-float cast sequencer.
// Optional zero-skip behaviour is selected by SNOW64_BFLOAT16_VECTOR_CAST_SKIP_ZERO_EN.
package snow64_bfloat16_vector_cast_from_int_pkg;

  localparam int WIDTH__SNOW64_VECTOR_LINE    = 256;
  localparam int WIDTH__SNOW64_BFLOAT16       = 16;
  localparam int MAX_ELEMS__SNOW64_VECTOR     = WIDTH__SNOW64_VECTOR_LINE / 8;
  localparam int WIDTH__SNOW64_VECTOR_RESULT  = MAX_ELEMS__SNOW64_VECTOR * WIDTH__SNOW64_BFLOAT16;

  typedef enum logic [1:0] {
    IntTypSz8  = 2'd0,
    IntTypSz16 = 2'd1,
    IntTypSz32 = 2'd2,
    IntTypSz64 = 2'd3
  } IntTypSz;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } VectorCastState;

  typedef struct packed {
    logic [WIDTH__SNOW64_VECTOR_LINE-1:0] data;
    logic [1:0]                           int_type_size;
    logic                                 type_signedness;
  } VectorCastCmd;

  typedef struct packed {
    logic         start;
    VectorCastCmd cmd;
  } PortIn_VectorCastFromInt;

  typedef struct packed {
    logic                                   valid;
    logic                                   can_accept_cmd;
    logic [WIDTH__SNOW64_VECTOR_RESULT-1:0] data;
    logic [5:0]                             num_elems;
  } PortOut_VectorCastFromInt;

  function automatic logic [5:0] num_elems_for(input logic [1:0] int_type_size);
    case (int_type_size)
      IntTypSz8:  return 6'd32;
      IntTypSz16: return 6'd16;
      IntTypSz32: return 6'd8;
      default:    return 6'd4;
    endcase
  endfunction

endpackage

// File: rtl/snow64_vector_elem_extract.sv
// Picks element [index] out of a packed vector line and zero-extends it to 64 bits.
// Purely combinational; unaffected by SNOW64_BFLOAT16_VECTOR_CAST_SKIP_ZERO_EN.
module snow64_vector_elem_extract
  import snow64_bfloat16_vector_cast_from_int_pkg::*;
(
  input  logic [WIDTH__SNOW64_VECTOR_LINE-1:0] line_i,
  input  logic [4:0]                           index_i,
  input  logic [1:0]                           int_type_size_i,
  output logic [63:0]                          elem_o
);

  logic [7:0]  lanes8  [32];
  logic [15:0] lanes16 [16];
  logic [31:0] lanes32 [8];
  logic [63:0] lanes64 [4];

  for (genvar gi = 0; gi < 32; gi++) begin : g_l8
    assign lanes8[gi] = line_i[gi*8 +: 8];
  end
  for (genvar gi = 0; gi < 16; gi++) begin : g_l16
    assign lanes16[gi] = line_i[gi*16 +: 16];
  end
  for (genvar gi = 0; gi < 8; gi++) begin : g_l32
    assign lanes32[gi] = line_i[gi*32 +: 32];
  end
  for (genvar gi = 0; gi < 4; gi++) begin : g_l64
    assign lanes64[gi] = line_i[gi*64 +: 64];
  end

  always_comb begin
    elem_o = '0;
    case (int_type_size_i)
      IntTypSz8:  elem_o = {56'd0, lanes8[index_i]};
      IntTypSz16: elem_o = {48'd0, lanes16[index_i[3:0]]};
      IntTypSz32: elem_o = {32'd0, lanes32[index_i[2:0]]};
      default:    elem_o = lanes64[index_i[1:0]];
    endcase
  end

endmodule

// File: rtl/snow64_bfloat16_vector_cast_from_int.sv
// Sequences a vector line through an external scalar BFloat16 int-to-float cast unit.
// Define SNOW64_BFLOAT16_VECTOR_CAST_SKIP_ZERO_EN to bypass the cast unit for zero elements.
module snow64_bfloat16_vector_cast_from_int
  import snow64_bfloat16_vector_cast_from_int_pkg::*;
#(
  parameter int LINE_WIDTH = WIDTH__SNOW64_VECTOR_LINE,
  parameter int BF16_WIDTH = WIDTH__SNOW64_BFLOAT16,
  parameter int MAX_ELEMS  = MAX_ELEMS__SNOW64_VECTOR
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_start,
  input  logic [LINE_WIDTH-1:0]           in_data,
  input  logic [1:0]                      in_int_type_size,
  input  logic                            in_type_signedness,
  output logic                            out_cast_start,
  output logic [63:0]                     out_cast_to_cast,
  output logic [1:0]                      out_cast_int_type_size,
  output logic                            out_cast_type_signedness,
  input  logic                            in_cast_valid,
  input  logic                            in_cast_can_accept_cmd,
  input  logic [BF16_WIDTH-1:0]           in_cast_data,
  output logic                            out_valid,
  output logic                            out_can_accept_cmd,
  output logic [MAX_ELEMS*BF16_WIDTH-1:0] out_data,
  output logic [5:0]                      out_num_elems
);

  PortIn_VectorCastFromInt  port_in;
  VectorCastState           state_q;
  logic [4:0]               index_q;
  VectorCastCmd             cmd_q;
  PortOut_VectorCastFromInt out_q;

  logic [63:0] elem;
  logic [5:0]  n_elems;
  logic        is_last;
  logic        elem_skip;
  logic        advance;
  logic [15:0] lane_d;

  assign port_in.start                   = in_start;
  assign port_in.cmd.data                = in_data;
  assign port_in.cmd.int_type_size       = in_int_type_size;
  assign port_in.cmd.type_signedness     = in_type_signedness;

  snow64_vector_elem_extract u_elem_extract (
    .line_i          (cmd_q.data),
    .index_i         (index_q),
    .int_type_size_i (cmd_q.int_type_size),
    .elem_o          (elem)
  );

  assign n_elems = num_elems_for(cmd_q.int_type_size);
  assign is_last = ({1'b0, index_q} == (n_elems - 6'd1));

`ifdef SNOW64_BFLOAT16_VECTOR_CAST_SKIP_ZERO_EN
  // A zero integer always casts to +0.0, so the cast unit can be bypassed.
  assign elem_skip = (state_q == StIssue) && (elem == 64'd0);
`else
  assign elem_skip = 1'b0;
`endif

  assign advance = elem_skip || ((state_q == StWait) && in_cast_valid);
  assign lane_d  = elem_skip ? 16'h0000 : in_cast_data;

  assign out_cast_start           = (state_q == StIssue) && in_cast_can_accept_cmd && !elem_skip;
  assign out_cast_to_cast         = elem;
  assign out_cast_int_type_size   = cmd_q.int_type_size;
  assign out_cast_type_signedness = cmd_q.type_signedness;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= StIdle;
      index_q              <= '0;
      cmd_q                <= '0;
      out_q.valid          <= 1'b0;
      out_q.can_accept_cmd <= 1'b1;
      out_q.data           <= '0;
      out_q.num_elems      <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          out_q.valid <= 1'b0;
          state_q     <= StIdle;
          if (port_in.start) begin
            cmd_q                <= port_in.cmd;
            index_q              <= '0;
            out_q.data           <= '0;
            out_q.can_accept_cmd <= 1'b0;
            state_q              <= StIssue;
          end
        end
        StIssue, StWait: begin
          if (advance) begin
            out_q.data[{index_q, 4'b0000} +: 16] <= lane_d;
            if (is_last) begin
              state_q              <= StDone;
              out_q.valid          <= 1'b1;
              out_q.can_accept_cmd <= 1'b1;
              out_q.num_elems      <= n_elems;
            end else begin
              index_q <= index_q + 5'd1;
              state_q <= StIssue;
            end
          end else if ((state_q == StIssue) && in_cast_can_accept_cmd) begin
            state_q <= StWait;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid          = out_q.valid;
  assign out_can_accept_cmd = out_q.can_accept_cmd;
  assign out_data           = out_q.data;
  assign out_num_elems      = out_q.num_elems;

endmodule
